// File: rtl/bus_master_arbiter_pkg.sv
// ----------------------------------------------------------------------------
// bus_master_arbiter_pkg
// Shared definitions for the four-master shared-bus arbiter:
//   - FSM state encodings (BUS_ARB_ST_HOLD / BUS_ARB_ST_GAP)
//   - owner index constants BUS_OWNER_0..3
//   - bus direction levels READ / WRITE
//   - active-low level names ENABLE_ / DISABLE_
//   - candidate search helpers for round-robin and fixed-priority policies
// ----------------------------------------------------------------------------
package bus_master_arbiter_pkg;

    localparam int NUM_MASTERS = 4;

    typedef enum logic {
        BUS_ARB_ST_HOLD = 1'b0,
        BUS_ARB_ST_GAP  = 1'b1
    } bus_arb_state_e;

    localparam logic [1:0] BUS_OWNER_0 = 2'd0;
    localparam logic [1:0] BUS_OWNER_1 = 2'd1;
    localparam logic [1:0] BUS_OWNER_2 = 2'd2;
    localparam logic [1:0] BUS_OWNER_3 = 2'd3;

    localparam logic READ  = 1'b1;
    localparam logic WRITE = 1'b0;

    localparam logic ENABLE_  = 1'b0;
    localparam logic DISABLE_ = 1'b1;

    // Round-robin pick: {found, index}. Searches owner+1, owner+2, owner+3
    // (mod 4); the current owner is never part of its own search. Iterating
    // from the farthest slot down lets the nearest requester win.
    function automatic logic [2:0] bus_arb_rr_pick(input logic [1:0] owner,
                                                   input logic [3:0] req);
        logic [2:0] r;
        logic [1:0] idx;
        r = 3'b000;
        for (int i = 3; i >= 1; i--) begin
            idx = owner + 2'(i);
            if (req[idx]) r = {1'b1, idx};
        end
        return r;
    endfunction

    // Fixed-priority pick: {found, index} of the lowest-index requester.
    function automatic logic [2:0] bus_arb_fixed_pick(input logic [3:0] req);
        logic [2:0] r;
        r = 3'b000;
        for (int i = 3; i >= 0; i--) begin
            if (req[i]) r = {1'b1, 2'(i)};
        end
        return r;
    endfunction

endpackage

// File: rtl/bus_master_mux.sv
// ----------------------------------------------------------------------------
// bus_master_mux
// Combinational 4:1 select of the master-side address, strobe, direction and
// write data onto the shared slave side, keyed by the current owner index.
// The address strobe can be forced inactive (high) during the ownership gap;
// the other outputs keep following the selected master.
// Ports:
//   i_sel          owner index
//   i_force_as_hi  force o_as_ inactive
//   i_addr/i_as_/i_rw/i_wr_data  per-master bus signals, index = master
//   o_addr/o_as_/o_rw/o_wr_data  shared-bus outputs
// ----------------------------------------------------------------------------
module bus_master_mux
    import bus_master_arbiter_pkg::*;
#(
    parameter int WORD_ADDR_W = 30,
    parameter int WORD_DATA_W = 32
) (
    input  logic [1:0]                    i_sel,
    input  logic                          i_force_as_hi,
    input  logic [3:0][WORD_ADDR_W-1:0]   i_addr,
    input  logic [3:0]                    i_as_,
    input  logic [3:0]                    i_rw,
    input  logic [3:0][WORD_DATA_W-1:0]   i_wr_data,
    output logic [WORD_ADDR_W-1:0]        o_addr,
    output logic                          o_as_,
    output logic                          o_rw,
    output logic [WORD_DATA_W-1:0]        o_wr_data
);

    assign o_addr    = i_addr[i_sel];
    assign o_as_     = i_force_as_hi ? DISABLE_ : i_as_[i_sel];
    assign o_rw      = i_rw[i_sel];
    assign o_wr_data = i_wr_data[i_sel];

endmodule

// File: rtl/bus_master_arbiter.sv
// ----------------------------------------------------------------------------
// bus_master_arbiter
// Four-master shared-bus arbiter plus master multiplexer. The bus is always
// parked on one owner; ownership moves only when the owner releases its
// request (req_ high) and another master is requesting. Every change of owner
// inserts exactly one dead cycle (all grants high, s_as_ forced high).
//
// Configuration macro:
//   BUS_ARB_FIXED_PRIO_EN  defined   -> lowest-index requester wins (m0 first)
//                          undefined -> round-robin starting at owner+1
//
// Ports:
//   clk, reset                 clock, synchronous active-high reset
//   mN_req_ (N=0..3)           bus request, active low
//   mN_addr/mN_as_/mN_rw/mN_wr_data  master N bus signals
//   mN_grnt_                   grant, active low, at most one low
//   s_addr/s_as_/s_rw/s_wr_data     shared slave-side bus
// ----------------------------------------------------------------------------
module bus_master_arbiter
    import bus_master_arbiter_pkg::*;
#(
    parameter int WORD_ADDR_W = 30,
    parameter int WORD_DATA_W = 32
) (
    input  logic                   clk,
    input  logic                   reset,

    input  logic                   m0_req_,
    input  logic [WORD_ADDR_W-1:0] m0_addr,
    input  logic                   m0_as_,
    input  logic                   m0_rw,
    input  logic [WORD_DATA_W-1:0] m0_wr_data,
    output logic                   m0_grnt_,

    input  logic                   m1_req_,
    input  logic [WORD_ADDR_W-1:0] m1_addr,
    input  logic                   m1_as_,
    input  logic                   m1_rw,
    input  logic [WORD_DATA_W-1:0] m1_wr_data,
    output logic                   m1_grnt_,

    input  logic                   m2_req_,
    input  logic [WORD_ADDR_W-1:0] m2_addr,
    input  logic                   m2_as_,
    input  logic                   m2_rw,
    input  logic [WORD_DATA_W-1:0] m2_wr_data,
    output logic                   m2_grnt_,

    input  logic                   m3_req_,
    input  logic [WORD_ADDR_W-1:0] m3_addr,
    input  logic                   m3_as_,
    input  logic                   m3_rw,
    input  logic [WORD_DATA_W-1:0] m3_wr_data,
    output logic                   m3_grnt_,

    output logic [WORD_ADDR_W-1:0] s_addr,
    output logic                   s_as_,
    output logic                   s_rw,
    output logic [WORD_DATA_W-1:0] s_wr_data
);

    bus_arb_state_e r_state;
    bus_arb_state_e w_state_nxt;
    logic [1:0]     r_owner;
    logic [1:0]     w_owner_nxt;

    logic [3:0]     w_req;      // active-high request vector
    logic [2:0]     w_pick;     // {found, index}
    logic [3:0]     w_grnt_;
    logic           w_gap;

    assign w_req = ~{m3_req_, m2_req_, m1_req_, m0_req_};

`ifdef BUS_ARB_FIXED_PRIO_EN
    assign w_pick = bus_arb_fixed_pick(w_req);
`else
    assign w_pick = bus_arb_rr_pick(r_owner, w_req);
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            r_owner <= BUS_OWNER_0;
            r_state <= BUS_ARB_ST_HOLD;
        end else begin
            r_owner <= w_owner_nxt;
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_owner_nxt = r_owner;
        w_state_nxt = r_state;
        w_grnt_     = {4{DISABLE_}};
        w_gap       = 1'b0;
        case (r_state)
            BUS_ARB_ST_HOLD: begin
                // Grant is parked on the owner whether or not it requests.
                w_grnt_[r_owner] = ENABLE_;
                // Any cycle the owner's request is high counts as a release.
                if (!w_req[r_owner] && w_pick[2] && (w_pick[1:0] != r_owner)) begin
                    w_owner_nxt = w_pick[1:0];
                    w_state_nxt = BUS_ARB_ST_GAP;
                end
            end
            BUS_ARB_ST_GAP: begin
                // Owner already points at the new master; just idle one cycle.
                w_gap       = 1'b1;
                w_state_nxt = BUS_ARB_ST_HOLD;
            end
            default: begin
                w_state_nxt = BUS_ARB_ST_HOLD;
            end
        endcase
    end

    assign m0_grnt_ = w_grnt_[0];
    assign m1_grnt_ = w_grnt_[1];
    assign m2_grnt_ = w_grnt_[2];
    assign m3_grnt_ = w_grnt_[3];

    bus_master_mux #(
        .WORD_ADDR_W (WORD_ADDR_W),
        .WORD_DATA_W (WORD_DATA_W)
    ) u_mux (
        .i_sel         (r_owner),
        .i_force_as_hi (w_gap),
        .i_addr        ({m3_addr, m2_addr, m1_addr, m0_addr}),
        .i_as_         ({m3_as_, m2_as_, m1_as_, m0_as_}),
        .i_rw          ({m3_rw, m2_rw, m1_rw, m0_rw}),
        .i_wr_data     ({m3_wr_data, m2_wr_data, m1_wr_data, m0_wr_data}),
        .o_addr        (s_addr),
        .o_as_         (s_as_),
        .o_rw          (s_rw),
        .o_wr_data     (s_wr_data)
    );

endmodule
